// File: rtl/simd_muland_pipe.sv
// Limb-serial SIMD lane-wise multiply / AND pipeline with valid/ready handshake.
// NL carry-save multiply stages followed by one carry-propagate output stage.
module simd_muland_pipe #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned LIMB_W  = 32,
    parameter int unsigned WCODE_W = 3,
    parameter int unsigned TAG_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  x_i,
    input  logic [DATA_W-1:0]  y_i,
    input  logic               mode_i,
    input  logic [WCODE_W-1:0] width_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  z_o,
    output logic [TAG_W-1:0]   tag_o
);

    localparam int unsigned NL   = DATA_W / LIMB_W;
    localparam int unsigned KMAX = $clog2(NL);

    typedef struct packed {
        logic               vld;
        logic               mode;
        logic [WCODE_W-1:0] w;
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  x;
        logic [DATA_W-1:0]  y;
        logic [DATA_W-1:0]  s;
        logic [DATA_W-1:0]  c;
    } stage_t;

    function automatic int unsigned limbs_per_lane(input logic [WCODE_W-1:0] w);
        return 32'd1 << w;
    endfunction

    function automatic logic [DATA_W-1:0] lane_mask(input int unsigned l, input logic [WCODE_W-1:0] w);
        int unsigned       hi;
        logic [DATA_W-1:0] m;
        hi = ~(limbs_per_lane(w) - 32'd1);
        m  = '0;
        for (int unsigned i = 0; i < NL; i++)
            if ((i & hi) == (l & hi)) m[i*LIMB_W +: LIMB_W] = '1;
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] msb_mask(input logic [WCODE_W-1:0] w);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NL; i++)
            if (((i + 32'd1) & (limbs_per_lane(w) - 32'd1)) == 32'd0) m[i*LIMB_W + LIMB_W - 1] = 1'b1;
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] lsb_mask(input logic [WCODE_W-1:0] w);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NL; i++)
            if ((i & (limbs_per_lane(w) - 32'd1)) == 32'd0) m[i*LIMB_W] = 1'b1;
        return m;
    endfunction

    // Lane-segmented add: lane MSBs are summed by XOR so no carry leaves a lane.
    function automatic logic [DATA_W-1:0] seg_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] h);
        return ((a & ~h) + (b & ~h)) ^ ((a ^ b) & h);
    endfunction

    // Limb l of y multiplies the lane of x that contains limb l, placed at that limb's in-lane offset.
    function automatic stage_t mul_step(input stage_t p, input int unsigned l);
        stage_t            n;
        logic [DATA_W-1:0] lm, yl, prod, pp, maj;
        int unsigned       off;
        lm   = lane_mask(l, p.w);
        yl   = '0;
        yl[LIMB_W-1:0] = p.y[l*LIMB_W +: LIMB_W];
        off  = (l & (limbs_per_lane(p.w) - 32'd1)) * LIMB_W;
        prod = (p.x & lm & {DATA_W{p.mode}}) * yl;
        pp   = (prod << off) & lm;
        maj  = (p.s & p.c) | (p.s & pp) | (p.c & pp);
        n    = p;
        n.s  = p.s ^ p.c ^ pp;
        n.c  = (maj << 1) & ~lsb_mask(p.w);
        return n;
    endfunction

    stage_t              st_q [NL];
    stage_t              st_d [NL];
    stage_t              prev [NL];
    stage_t              head;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   z_q, z_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                stall, advance;

    assign stall       = out_valid_q & ~out_ready_i;
    assign advance     = ~stall | flush_i;
    assign in_ready_o  = ~stall & ~flush_i;
    assign out_valid_o = out_valid_q;
    assign z_o         = z_q;
    assign tag_o       = tag_q;

    always_comb begin
        head      = '0;
        head.vld  = in_valid_i & in_ready_o;
        head.mode = mode_i;
        head.w    = (32'(width_i) > KMAX) ? WCODE_W'(KMAX) : width_i;
        head.tag  = tag_i;
        head.x    = x_i;
        head.y    = y_i;
        head.s    = mode_i ? '0 : (x_i & y_i);
        prev[0]   = head;
        for (int unsigned i = 1; i < NL; i++) prev[i] = st_q[i-1];
    end

    always_comb begin
        st_d        = st_q;
        out_valid_d = out_valid_q;
        z_d         = z_q;
        tag_d       = tag_q;
        if (advance) begin
            for (int unsigned i = 0; i < NL; i++) begin
                st_d[i]     = mul_step(prev[i], i);
                st_d[i].vld = prev[i].vld & ~flush_i;
            end
            out_valid_d = st_q[NL-1].vld & ~flush_i;
            if (st_q[NL-1].vld) begin
                z_d   = seg_add(st_q[NL-1].s, st_q[NL-1].c, msb_mask(st_q[NL-1].w));
                tag_d = st_q[NL-1].tag;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < NL; i++) st_q[i] <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            tag_q       <= '0;
        end else begin
            for (int unsigned i = 0; i < NL; i++) st_q[i] <= st_d[i];
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            tag_q       <= tag_d;
        end
    end

endmodule
